// File: rtl/baccarat_pkg.sv
// Shared types and tableau helpers
// for the baccarat round sequencer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_BANK,
    S_D3,
    S_DONE
  } state_t;

  // Face cards and tens count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

  // Banker third-card tableau given the player's third card value.
  function automatic logic banker_draws(input logic [3:0] dscore,
                                        input logic [3:0] v);
    logic d;
    d = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: d = 1'b1;
      4'd3: d = (v != 4'd8);
      4'd4: d = (v >= 4'd2) && (v <= 4'd7);
      4'd5: d = (v >= 4'd4) && (v <= 4'd7);
      4'd6: d = (v >= 4'd6) && (v <= 4'd7);
      default: d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/baccarat_ctrl_banker_rule.sv
// Banker draw decision from banker score
// and the player's third card rank.
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  // Pure combinational tableau lookup.
  assign draw = banker_draws(dscore, card_value(pcard3));

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat round sequencer: deals cards,
// applies third-card rules, shows winner.
module baccarat_ctrl
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore_out,
  input  logic [3:0] dscore_out,
  input  logic [3:0] pcard3_out,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  state_t     state_q, state_d;
  logic [5:0] load_q, load_d;
  logic       done_q, done_d;
  logic       bank_draw;
  logic       natural;

  banker_rule u_rule (
    .dscore (dscore_out),
    .pcard3 (pcard3_out),
    .draw   (bank_draw)
  );

  assign natural = (pscore_out >= 4'd8) || (dscore_out >= 4'd8);

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_P1;
      S_P1:   state_d = S_D1;
      S_D1:   state_d = S_P2;
      S_P2:   state_d = S_D2;
      S_D2:   state_d = S_EVAL;
      S_EVAL: begin
        if (natural)
          state_d = S_DONE;
        else if (pscore_out <= 4'd5)
          state_d = S_P3;
        else if (dscore_out <= 4'd5)
          state_d = S_D3;
        else
          state_d = S_DONE;
      end
      S_P3:   state_d = S_BANK;
      S_BANK: state_d = bank_draw ? S_D3 : S_DONE;
      S_D3:   state_d = S_DONE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Order: pcard1, dcard1, pcard2, dcard2, pcard3, dcard3
    load_d = 6'b0;
    case (state_d)
      S_P1: load_d = 6'b100000;
      S_D1: load_d = 6'b010000;
      S_P2: load_d = 6'b001000;
      S_D2: load_d = 6'b000100;
      S_P3: load_d = 6'b000010;
      S_D3: load_d = 6'b000001;
      default: load_d = 6'b0;
    endcase
    done_d = (state_d == S_DONE);
  end

  // State and Moore outputs, synchronous reset.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_q <= S_IDLE;
      load_q  <= 6'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign load_pcard1 = load_q[5];
  assign load_dcard1 = load_q[4];
  assign load_pcard2 = load_q[3];
  assign load_dcard2 = load_q[2];
  assign load_pcard3 = load_q[1];
  assign load_dcard3 = load_q[0];
  assign round_done  = done_q;

  // Tie lights both lamps.
  assign player_win_light = done_q && (pscore_out >= dscore_out);
  assign dealer_win_light = done_q && (dscore_out >= pscore_out);

endmodule

// File: doc/baccarat_ctrl.md
# baccarat_ctrl

Round sequencer for the Baccarat engine. It drives the six card-load enables of `datapath` and reads back `pscore_out`, `dscore_out` and `pcard3_out` from it. It deals the four opening cards, applies the natural, player-third-card and banker-third-card tableau rules, and then reports the winner on two lights. It is a Moore FSM clocked once per game step on the same clock as the datapath card registers.

## Interface
- No parameters.
- `slow_clock  input  1  game-step clock, shared with the datapath card registers`
- `resetb  input  1  synchronous, active-high reset (level 1 sampled at a rising edge resets)`
- `pscore_out  input  4  player score 0..9 from datapath, combinational from registered cards`
- `dscore_out  input  4  banker score 0..9 from datapath`
- `pcard3_out  input  4  player third card rank 0..13 (1=A, 11..13=J/Q/K, 0=none)`
- `load_pcard1, load_pcard2, load_pcard3  output  1 each  player card register enables`
- `load_dcard1, load_dcard2, load_dcard3  output  1 each  banker card register enables`
- `player_win_light  output  1  player won, or tie`
- `dealer_win_light  output  1  banker won, or tie`
- `round_done  output  1  high in DONE`

## Operation
- States: IDLE, P1, D1, P2, D2, EVAL, P3, BANK, D3, DONE.
- Exactly one load output is high per state: P1→`load_pcard1`, D1→`load_dcard1`, P2→`load_pcard2`, D2→`load_dcard2`, P3→`load_pcard3`, D3→`load_dcard3`.
- All loads are 0 in IDLE, EVAL, BANK and DONE.
- Fixed transitions: IDLE→P1→D1→P2→D2→EVAL.
- EVAL:
  - pscore ≥ 8 or dscore ≥ 8 (natural) → DONE.
  - else pscore ≤ 5 → P3.
  - else (player stands at 6/7): dscore ≤ 5 → D3, otherwise → DONE.
- P3 → BANK.
- BANK: banker draw decision uses dscore and v, where v = card value of `pcard3_out` (ranks 10..13 give 0, otherwise v = rank).
  - dscore 0..2 → D3.
  - dscore 3: draw unless v = 8.
  - dscore 4: draw if v in 2..7.
  - dscore 5: draw if v in 4..7.
  - dscore 6: draw if v in 6..7.
  - dscore 7: stand.
  - Draw → D3; stand → DONE.
- D3 → DONE.
- DONE is absorbing until reset.
- Lights are asserted only in DONE and are combinational from the current scores:
  - pscore > dscore → `player_win_light`=1, `dealer_win_light`=0.
  - dscore > pscore → `dealer_win_light`=1, `player_win_light`=0.
  - Equal → both 1.
- Outside DONE both lights are 0.
- `round_done` = (state == DONE).
- Score inputs outside 0..9 are not expected. Any score ≥ 8 is treated as a natural.

## Timing
- Reset: state←IDLE at the sampling edge. During and immediately after reset, all loads, both lights and `round_done` are 0.
- Cycle numbering: C0 is the first cycle in IDLE after reset is released.
- Opening deal: P1=C1, D1=C2, P2=C3, D2=C4, EVAL=C5. A load asserted in cycle Cn is captured by the datapath at the rising edge ending Cn.
- Scores read in EVAL reflect all four opening cards.
- Third-card paths:
  - Natural: DONE at C6.
  - Player stands, banker draws: D3=C6, DONE=C7.
  - Player draws: P3=C6, BANK=C7 (`pcard3_out` valid there), then D3=C8 / DONE=C9, or DONE=C8 if the banker stands.
- Lights are valid from the first DONE cycle, so they include the `dcard3` captured at the end of D3.
- Reset asserted in any state, including mid-deal: IDLE on the next cycle, no further loads. The datapath is reset separately by the top level.
- Every next-state decision is a registered function of the current state and current inputs. No output depends on inputs except the lights in DONE.

## Structure
- `baccarat_pkg`: state enum `state_t` (10 states); function `card_value(rank)` (10..13→0); function `banker_draws(dscore, v)` implementing the tableau.
- Sub-module `banker_rule`: combinational wrapper of `banker_draws`, used in BANK and reusable by the bench scoreboard.
- Top `baccarat_ctrl`: state register, next-state logic, output decode.

## Test plan
Bench pairs the block with a behavioural datapath model fed a scripted card sequence.
- Cards P1=4, D1=2, P2=4, D2=3 (pscore 8, dscore 5) → no third-card loads; DONE at C6; `player_win_light`=1, `dealer_win_light`=0.
- P=2,3 (5), D=3,3 (6), P3=6 → `load_pcard3` at C6, BANK at C7, `load_dcard3` at C8, DONE at C9.
- P=3,3 (6), D=2,3 (5) → banker draws directly: `load_dcard3` at C6, DONE at C7, no `load_pcard3`.
- P=1,2 (3), D=1,3 (4), P3=13 (v=0) → banker stands; DONE at C8, no `load_dcard3`. Repeat with P3=2 → `load_dcard3` at C8.
- P=3,4 (7), D=5,2 (7) → DONE at C6, both lights 1.
- Assert reset during P3 (C6) → C7 is IDLE, all loads and lights 0. After release the round restarts with P1 at the second post-release cycle.
